reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NumDomains, default 2, the number of downstream domains (1..8).
REQ-002 SHALL have parameter HoldCycles, default 4, the cycles between sequencing steps (>=1).
REQ-003 SHALL have parameter ClkEnLead, default 2, the cycles from clock enable to first reset release (>=1).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port req_i, input, 1 bit: soft-reset request, level, held until ack_o.
REQ-007 SHALL have port ack_o, output, 1 bit: one-cycle pulse when the soft-reset sequence completes.
REQ-008 SHALL have port done_o, output, 1 bit: high while all domains are out of reset (RUN).
REQ-009 SHALL have port clk_en_o, output, NumDomains bits: per-domain clock enable.
REQ-010 SHALL have port rst_no, output, NumDomains bits: per-domain active-low reset.

Function
REQ-011 SHALL implement states HOLD, ENABLE, RELEASE, RUN and DRAIN, with one step counter of width $clog2(max(HoldCycles,ClkEnLead)+1) and a domain index of width $clog2(NumDomains+1).
REQ-012 SHALL register every output, with no combinational path from inputs to outputs.
REQ-013 HOLD SHALL keep rst_no all 0 and clk_en_o all 0 for HoldCycles edges, then go to ENABLE and set clk_en_o all 1.
REQ-014 ENABLE SHALL last ClkEnLead edges, then go to RELEASE and drive rst_no[0] to 1.
REQ-015 RELEASE SHALL drive rst_no[i] to 1 exactly HoldCycles edges after rst_no[i-1], in ascending index order.
REQ-016 When rst_no[NumDomains-1] rises, the block SHALL raise done_o on the same edge and enter RUN; with NumDomains=1, done_o rises with rst_no[0].
REQ-017 In RUN, req_i=1 SHALL cause DRAIN to be entered and done_o to drop on the next edge.
REQ-018 req_i in any state other than RUN SHALL be ignored and not latched.
REQ-019 In DRAIN, the rst_no assertion pattern SHALL follow REQ-027/REQ-028.
REQ-020 HoldCycles edges after the last rst_no falls, the block SHALL drop clk_en_o to all 0 and enter HOLD, which then proceeds per REQ-013.
REQ-021 ack_o SHALL pulse high for one cycle on the edge on which done_o re-rises after a soft reset, and never after an rst_i-initiated sequence.
REQ-022 If req_i is still high one cycle after ack_o, the block SHALL start a new DRAIN; dropping req_i on ack_o is the requester's duty.

Reset
REQ-023 rst_i SHALL have priority over every other input and state.
REQ-024 On any edge with rst_i=1 the block SHALL set state=HOLD, counters=0, rst_no=0, clk_en_o=0, done_o=0 and ack_o=0.
REQ-025 rst_i asserted mid-RELEASE or mid-DRAIN SHALL abort the sequence with no ack_o pulse; the sequence restarts from HOLD on the first edge with rst_i=0.
REQ-026 Edge numbering: edge 1 is the first rising edge sampling rst_i=0.

Configuration
REQ-027 With macro RST_SEQ_REVERSE_ASSERT_EN defined, DRAIN SHALL drive rst_no[NumDomains-1] low on the edge it sees req_i, then each lower index low HoldCycles edges later, in descending order.
REQ-028 Without RST_SEQ_REVERSE_ASSERT_EN, DRAIN SHALL drive all rst_no low together on the edge it sees req_i.
REQ-029 In both configurations, clk_en_o SHALL stay 1 throughout DRAIN until REQ-020 applies.

Verification (defaults N=2, H=4, L=2 unless stated)
REQ-030 Drop rst_i -> clk_en_o=2'b11 at edge 4, rst_no=2'b01 at edge 6, rst_no=2'b11 and done_o=1 at edge 10, ack_o stays 0.
REQ-031 req_i=1 sampled at RUN edge k (macro off) -> rst_no=00 and done_o=0 at k; clk_en_o=00 at k+4; clk_en_o=11 at k+8; rst_no=01 at k+10; rst_no=11 with done_o=1 and ack_o=1 for one cycle at k+14.
REQ-032 Same stimulus as REQ-031 with RST_SEQ_REVERSE_ASSERT_EN -> rst_no=01 at k, rst_no=00 at k+4, clk_en_o=00 at k+8, ack_o pulse at k+18.
REQ-033 rst_i pulsed at edge 8 (during RELEASE) -> all outputs 0 next edge, no ack_o; the sequence repeats REQ-030 timing from the new edge 1.
REQ-034 req_i held high during HOLD/RELEASE, then dropped before RUN -> no DRAIN, no ack_o; req_i held through ack_o -> second DRAIN begins one edge after ack_o.
REQ-035 N=1, H=1, L=1 -> clk_en_o=1 at edge 1, rst_no=1 and done_o=1 at edge 2.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds domains in reset, enables their clocks, then releases resets one by one.
// Optional `RST_SEQ_REVERSE_ASSERT_EN`: soft-reset drain asserts domain resets top-down instead of all at once.
module reset_sequencer #(
    parameter int NumDomains = 2,
    parameter int HoldCycles = 4,
    parameter int ClkEnLead  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  ack_o,
    output logic                  done_o,
    output logic [NumDomains-1:0] clk_en_o,
    output logic [NumDomains-1:0] rst_no
);

    localparam int MaxStep = (HoldCycles > ClkEnLead) ? HoldCycles : ClkEnLead;
    localparam int CntW    = $clog2(MaxStep + 1);
    localparam int IdxW    = $clog2(NumDomains + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] LeadLast = CntW'(ClkEnLead - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumDomains - 1);
    localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);

    typedef enum logic [2:0] {
        HOLD,
        ENABLE,
        RELEASE,
        RUN,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    soft_q, soft_d;
    logic [NumDomains-1:0]   rst_n_d;
    logic [NumDomains-1:0]   clk_en_d;
    logic                    done_d;
    logic                    ack_d;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        soft_d   = soft_q;
        rst_n_d  = rst_no;
        clk_en_d = clk_en_o;
        done_d   = done_o;
        ack_d    = 1'b0;

        unique case (state_q)
            HOLD: begin
                if (cnt_q == HoldLast) begin
                    state_d  = ENABLE;
                    cnt_d    = '0;
                    clk_en_d = '1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            ENABLE: begin
                if (cnt_q == LeadLast) begin
                    cnt_d      = '0;
                    rst_n_d[0] = 1'b1;
                    if (NumDomains == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        ack_d   = soft_q;
                        soft_d  = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IdxOne;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            RELEASE: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    for (int i = 0; i < NumDomains; i++) begin
                        if (IdxW'(i) == idx_q) rst_n_d[i] = 1'b1;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        ack_d   = soft_q;
                        soft_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            RUN: begin
                if (req_i) begin
                    state_d = DRAIN;
                    done_d  = 1'b0;
                    soft_d  = 1'b1;
                    cnt_d   = '0;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
                    rst_n_d[NumDomains-1] = 1'b0;
                    idx_d                 = LastIdx;
`else
                    rst_n_d = '0;
                    idx_d   = '0;
`endif
                end
            end

            DRAIN: begin
                // idx_q counts the domains still out of reset; the lowest ones drop last.
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d  = HOLD;
                        clk_en_d = '0;
                    end else begin
                        for (int i = 0; i < NumDomains; i++) begin
                            if (IdxW'(i) == idx_q - IdxOne) rst_n_d[i] = 1'b0;
                        end
                        idx_d = idx_q - IdxOne;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            default: state_d = HOLD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            soft_q   <= 1'b0;
            rst_no   <= '0;
            clk_en_o <= '0;
            done_o   <= 1'b0;
            ack_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            soft_q   <= soft_d;
            rst_no   <= rst_n_d;
            clk_en_o <= clk_en_d;
            done_o   <= done_d;
            ack_o    <= ack_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance (N=2,H=4,L=2) plus a minimal one (N=1,H=1,L=1).
// Expectations follow `RST_SEQ_REVERSE_ASSERT_EN` when the bench is built with it.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       req;
    logic       req_s;
    logic       ack, done;
    logic [1:0] clk_en, rst_n;
    logic       ack_s, done_s;
    logic [0:0] clk_en_s, rst_n_s;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef RST_SEQ_REVERSE_ASSERT_EN
    localparam int AckAt = 18;
`else
    localparam int AckAt = 14;
`endif

    reset_sequencer dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .ack_o   (ack),
        .done_o  (done),
        .clk_en_o(clk_en),
        .rst_no  (rst_n)
    );

    reset_sequencer #(
        .NumDomains(1),
        .HoldCycles(1),
        .ClkEnLead (1)
    ) dut_s (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req_s),
        .ack_o   (ack_s),
        .done_o  (done_s),
        .clk_en_o(clk_en_s),
        .rst_no  (rst_n_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [1:0] ce, input logic [1:0] rn,
                            input logic d, input logic a);
        chk({tag, " clk_en"}, 8'(clk_en), 8'(ce));
        chk({tag, " rst_n"},  8'(rst_n),  8'(rn));
        chk({tag, " done"},   8'(done),   8'(d));
        chk({tag, " ack"},    8'(ack),    8'(a));
    endtask

    task automatic chk_small(input string tag, input logic ce, input logic rn,
                             input logic d, input logic a);
        chk({tag, " s_clk_en"}, 8'(clk_en_s), 8'(ce));
        chk({tag, " s_rst_n"},  8'(rst_n_s),  8'(rn));
        chk({tag, " s_done"},   8'(done_s),   8'(d));
        chk({tag, " s_ack"},    8'(ack_s),    8'(a));
    endtask

    // One rst_i edge, then both instances must show everything low.
    task automatic reset_edge(input string tag);
        rst = 1'b1;
        req = 1'b0;
        tick();
        chk_main(tag, 2'b00, 2'b00, 1'b0, 1'b0);
        chk_small(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Edges 1..n_edges after reset release; req is high on edges 1..req_until.
    task automatic bringup(input string tag, input int n_edges, input int req_until);
        for (int e = 1; e <= n_edges; e++) begin
            req = (e <= req_until);
            tick();
            chk_main($sformatf("%s e%0d", tag, e),
                     (e >= 4) ? 2'b11 : 2'b00,
                     (e >= 10) ? 2'b11 : ((e >= 6) ? 2'b01 : 2'b00),
                     (e >= 10), 1'b0);
            chk_small($sformatf("%s e%0d", tag, e), 1'b1, (e >= 2), (e >= 2), 1'b0);
        end
        req = 1'b0;
    endtask

    // Soft reset from RUN; edge k is j=0. With keep_req the edge after ack must start a new drain.
    task automatic drain(input string tag, input bit keep_req);
        logic [1:0] ce, rn;
        int jj;
        req = 1'b1;
        for (int j = 0; j <= AckAt + 1; j++) begin
            tick();
            if (!keep_req) req = 1'b0;
            jj = (keep_req && j == AckAt + 1) ? 0 : j;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            ce = (jj < 8 || jj >= 12) ? 2'b11 : 2'b00;
            rn = (jj >= 18) ? 2'b11 : (jj >= 14) ? 2'b01 : (jj >= 4) ? 2'b00 : 2'b01;
`else
            ce = (jj < 4 || jj >= 8) ? 2'b11 : 2'b00;
            rn = (jj >= 14) ? 2'b11 : (jj >= 10) ? 2'b01 : 2'b00;
`endif
            chk_main($sformatf("%s k+%0d", tag, j), ce, rn, (jj >= AckAt), (jj == AckAt));
        end
        req = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        req_s = 1'b0;
        tick();
        reset_edge("reset");

        bringup("boot", 12, 0);
        drain("drain", 1'b0);
        drain("drain_hold", 1'b1);

        // Abort in the middle of a drain: no ack, clean restart.
        tick();
        reset_edge("abort_drain");
        bringup("req_ignored", 12, 9);

        // Abort in the middle of release at edge 8.
        reset_edge("reset2");
        bringup("part", 7, 0);
        reset_edge("abort_rel e8");
        bringup("reboot", 10, 0);

        // Minimal instance soft reset: one edge per step.
        req_s = 1'b1;
        tick();
        req_s = 1'b0;
        chk_small("s k", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_small("s k+1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_small("s k+2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_small("s k+3", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk_small("s k+4", 1'b1, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
